// File: rtl/i2c_bus_arbiter_if.sv
// Bus bundle between the I2C master arbiter and its four clients.
// The slave modport is the arbiter's view; the master modport is the client/driver side.
interface i2c_bus_arbiter_if;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] fail;
   logic       i2c_bus_busy;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic [3:0] client_reset;
   logic       abort;
   logic       txn_fail;
   logic [1:0] state_out;

   modport master (
      output req, done, fail, i2c_bus_busy,
      input  grant, grant_valid, grant_id, client_reset, abort, txn_fail, state_out
   );

   modport slave (
      input  req, done, fail, i2c_bus_busy,
      output grant, grant_valid, grant_id, client_reset, abort, txn_fail, state_out
   );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Four-client arbiter for a shared I2C master: grant timeout, bus-busy release and guard gap.
// Define I2C_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority (client 0 highest).
module i2c_bus_arbiter #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
   parameter logic [3:0]  GUARD_CYCLES   = 4'd4
) (
   input logic              clk,
   input logic              reset_n,
   i2c_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2,
      S_GUARD   = 2'd3
   } state_t;

   state_t      state_r;
   logic [3:0]  grant_r;
   logic        grant_valid_r;
   logic [1:0]  grant_id_r;
   logic [3:0]  client_reset_r;
   logic        abort_r;
   logic        txn_fail_r;
   logic [15:0] timer_r;
   logic [3:0]  guard_r;
   logic [1:0]  winner_s;
   logic        end_txn_s;
   logic        expire_s;

`ifdef I2C_ARB_ROUND_ROBIN_EN
   logic [1:0]  rr_ptr_r;

   function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic       found;
      pick_rr = ptr;
      found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx     = ptr + 2'(i);
         pick_rr = (!found && r[idx]) ? idx : pick_rr;
         found   = found | r[idx];
      end
   endfunction
`else
   function automatic logic [1:0] pick_fixed(input logic [3:0] r);
      pick_fixed = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         pick_fixed = r[i] ? 2'(i) : pick_fixed;
      end
   endfunction
`endif

   // Winner among current requests, used only when leaving S_IDLE.
   always_comb begin
      winner_s = 2'd0;
`ifdef I2C_ARB_ROUND_ROBIN_EN
      winner_s = pick_rr(bus.req, rr_ptr_r);
`else
      winner_s = pick_fixed(bus.req);
`endif
   end

   // Only the granted client's done/fail end the transaction; expiry means the timer reaches 0 this cycle.
   always_comb begin
      end_txn_s = bus.done[grant_id_r] | bus.fail[grant_id_r];
      expire_s  = (timer_r <= 16'd1);
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= S_IDLE;
         grant_r        <= 4'b0000;
         grant_valid_r  <= 1'b0;
         grant_id_r     <= 2'd0;
         client_reset_r <= 4'b0000;
         abort_r        <= 1'b0;
         txn_fail_r     <= 1'b0;
         timer_r        <= 16'd0;
         guard_r        <= 4'd0;
`ifdef I2C_ARB_ROUND_ROBIN_EN
         rr_ptr_r       <= 2'd0;
`endif
      end else begin
         client_reset_r <= 4'b0000;
         abort_r        <= 1'b0;
         txn_fail_r     <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.req != 4'b0000) begin
                  grant_r       <= 4'b0001 << winner_s;
                  grant_id_r    <= winner_s;
                  grant_valid_r <= 1'b1;
                  timer_r       <= TIMEOUT_CYCLES;
                  state_r       <= S_GRANT;
`ifdef I2C_ARB_ROUND_ROBIN_EN
                  rr_ptr_r      <= winner_s + 2'd1;
`endif
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_GRANT: begin
               timer_r <= (timer_r == 16'd0) ? 16'd0 : timer_r - 16'd1;
               if (end_txn_s) begin
                  grant_r       <= 4'b0000;
                  grant_valid_r <= 1'b0;
                  txn_fail_r    <= bus.fail[grant_id_r];
                  state_r       <= S_RELEASE;
               end else if (!bus.req[grant_id_r]) begin
                  grant_r       <= 4'b0000;
                  grant_valid_r <= 1'b0;
                  state_r       <= S_RELEASE;
               end else if (expire_s) begin
                  grant_r        <= 4'b0000;
                  grant_valid_r  <= 1'b0;
                  abort_r        <= 1'b1;
                  client_reset_r <= 4'b0001 << grant_id_r;
                  state_r        <= S_RELEASE;
               end else begin
                  state_r <= S_GRANT;
               end
            end
            S_RELEASE: begin
               if (bus.i2c_bus_busy) begin
                  state_r <= S_RELEASE;
               end else if (GUARD_CYCLES == 4'd0) begin
                  state_r <= S_IDLE;
               end else begin
                  guard_r <= GUARD_CYCLES;
                  state_r <= S_GUARD;
               end
            end
            S_GUARD: begin
               if (guard_r <= 4'd1) begin
                  guard_r <= 4'd0;
                  state_r <= S_IDLE;
               end else begin
                  guard_r <= guard_r - 4'd1;
                  state_r <= S_GUARD;
               end
            end
            default: begin
               grant_r       <= 4'b0000;
               grant_valid_r <= 1'b0;
               state_r       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.grant        = grant_r;
   assign bus.grant_valid  = grant_valid_r;
   assign bus.grant_id     = grant_id_r;
   assign bus.client_reset = client_reset_r;
   assign bus.abort        = abort_r;
   assign bus.txn_fail     = txn_fail_r;
   assign bus.state_out    = state_r;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter (TIMEOUT_CYCLES=10, GUARD_CYCLES=4).
// Expected grants go into a scoreboard queue when requests are driven and are popped when a grant appears.
module tb_i2c_bus_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [3:0] exp_q[$];

   i2c_bus_arbiter_if bus_if();

   i2c_bus_arbiter #(.TIMEOUT_CYCLES(16'd10), .GUARD_CYCLES(4'd4)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic [3:0] req_at_release);
      reset_n = 1'b0;
      bus_if.req = 4'b0000; bus_if.done = 4'b0000; bus_if.fail = 4'b0000;
      bus_if.i2c_bus_busy = 1'b0;
      step(); step();
      bus_if.req = req_at_release;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset(4'b0000);
      reset_n = 1'b0;
      step();
      n_vec++; if (bus_if.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want 0000", bus_if.grant); end
      n_vec++; if (bus_if.grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus_if.grant_valid); end
      n_vec++; if (bus_if.grant_id !== 2'd0) begin n_err++; $display("FAIL reset_id got %0d want 0", bus_if.grant_id); end
      n_vec++; if (bus_if.state_out !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", bus_if.state_out); end
      n_vec++; if ({bus_if.abort, bus_if.txn_fail, bus_if.client_reset} !== 6'b0) begin
         n_err++; $display("FAIL reset_pulses got %b want 000000", {bus_if.abort, bus_if.txn_fail, bus_if.client_reset}); end
   endtask

   task automatic test_basic();
      int guard_len;
      apply_reset(4'b0010);
      exp_q.push_back(4'b0010);
      step();
      n_vec++; if (bus_if.grant !== exp_q[0]) begin n_err++; $display("FAIL basic_grant got %b want %b", bus_if.grant, exp_q[0]); end
      void'(exp_q.pop_front());
      n_vec++; if (bus_if.grant_id !== 2'd1 || bus_if.grant_valid !== 1'b1 || bus_if.state_out !== 2'd1) begin
         n_err++; $display("FAIL basic_id_valid_state got %0d/%b/%0d want 1/1/1", bus_if.grant_id, bus_if.grant_valid, bus_if.state_out); end
      bus_if.done = 4'b0010; bus_if.req = 4'b0000;
      step();
      bus_if.done = 4'b0000;
      n_vec++; if (bus_if.grant !== 4'b0000 || bus_if.grant_valid !== 1'b0 || bus_if.state_out !== 2'd2) begin
         n_err++; $display("FAIL basic_release got %b/%b/%0d want 0000/0/2", bus_if.grant, bus_if.grant_valid, bus_if.state_out); end
      n_vec++; if (bus_if.grant_id !== 2'd1 || bus_if.txn_fail !== 1'b0) begin
         n_err++; $display("FAIL basic_id_hold got %0d/%b want 1/0", bus_if.grant_id, bus_if.txn_fail); end
      step();
      guard_len = 0;
      for (int t = 0; t < 20 && bus_if.state_out == 2'd3; t++) begin
         guard_len++;
         step();
      end
      n_vec++; if (guard_len !== 4) begin n_err++; $display("FAIL guard_len got %0d want 4", guard_len); end
      n_vec++; if (bus_if.state_out !== 2'd0) begin n_err++; $display("FAIL guard_to_idle got %0d want 0", bus_if.state_out); end
   endtask

   task automatic test_priority();
      int   n_grants;
      logic got;
      logic [3:0] e;
`ifdef I2C_ARB_ROUND_ROBIN_EN
      n_grants = 5;
`else
      n_grants = 3;
`endif
      apply_reset(4'b1111);
      for (int k = 0; k < n_grants; k++) begin
`ifdef I2C_ARB_ROUND_ROBIN_EN
         exp_q.push_back(4'b0001 << (k % 4));
`else
         exp_q.push_back(4'b0001);
`endif
         got = 1'b0;
         for (int t = 0; t < 40 && !got; t++) begin
            if (bus_if.grant_valid) got = 1'b1;
            else step();
         end
         e = exp_q.pop_front();
         n_vec++; if (!got || bus_if.grant !== e) begin
            n_err++; $display("FAIL order_grant%0d got %b want %b (seen=%b)", k, bus_if.grant, e, got); end
         bus_if.done = bus_if.grant;
         step();
         bus_if.done = 4'b0000;
      end
   endtask

   task automatic test_timeout();
      int abort_at = -1;
      int abort_cnt = 0;
      logic [3:0] cr_seen = 4'b0000;
      logic [3:0] g_at = 4'b1111;
      apply_reset(4'b0100);
      step();
      n_vec++; if (bus_if.grant !== 4'b0100) begin n_err++; $display("FAIL to_grant got %b want 0100", bus_if.grant); end
      for (int k = 1; k <= 12; k++) begin
         step();
         if (bus_if.abort) begin
            abort_cnt++;
            if (abort_at < 0) begin abort_at = k; cr_seen = bus_if.client_reset; g_at = bus_if.grant; end
         end
      end
      n_vec++; if (abort_at !== 10) begin n_err++; $display("FAIL to_abort_cycle got %0d want 10", abort_at); end
      n_vec++; if (cr_seen !== 4'b0100) begin n_err++; $display("FAIL to_client_reset got %b want 0100", cr_seen); end
      n_vec++; if (abort_cnt !== 1) begin n_err++; $display("FAIL to_abort_width got %0d want 1", abort_cnt); end
      n_vec++; if (g_at !== 4'b0000) begin n_err++; $display("FAIL to_grant_cleared got %b want 0000", g_at); end
   endtask

   task automatic test_ignore();
      logic got;
      logic [3:0] e;
      apply_reset(4'b0010);
      step();
      bus_if.req = 4'b1010; bus_if.done = 4'b1000; bus_if.fail = 4'b1000;
      step();
      bus_if.done = 4'b0000; bus_if.fail = 4'b0000;
      step();
      n_vec++; if (bus_if.grant !== 4'b0010 || bus_if.state_out !== 2'd1) begin
         n_err++; $display("FAIL ignore_grant got %b/%0d want 0010/1", bus_if.grant, bus_if.state_out); end
      n_vec++; if (bus_if.txn_fail !== 1'b0) begin n_err++; $display("FAIL ignore_txn_fail got %b want 0", bus_if.txn_fail); end
      bus_if.done = 4'b0010; bus_if.req = 4'b1000;
      exp_q.push_back(4'b1000);
      step();
      bus_if.done = 4'b0000;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
         if (bus_if.grant_valid) got = 1'b1;
         else step();
      end
      e = exp_q.pop_front();
      n_vec++; if (!got || bus_if.grant !== e) begin n_err++; $display("FAIL pending_grant got %b want %b", bus_if.grant, e); end
      bus_if.fail = 4'b1000;
      step();
      bus_if.fail = 4'b0000; bus_if.req = 4'b0000;
      n_vec++; if (bus_if.txn_fail !== 1'b1 || bus_if.grant !== 4'b0000 || bus_if.state_out !== 2'd2) begin
         n_err++; $display("FAIL fail_release got %b/%b/%0d want 1/0000/2", bus_if.txn_fail, bus_if.grant, bus_if.state_out); end
      step();
      n_vec++; if (bus_if.txn_fail !== 1'b0) begin n_err++; $display("FAIL txn_fail_width got %b want 0", bus_if.txn_fail); end
   endtask

   task automatic test_coincide();
      apply_reset(4'b0001);
      step();
      for (int k = 1; k <= 9; k++) step();
      bus_if.done = 4'b0001; bus_if.req = 4'b0000;
      step();
      bus_if.done = 4'b0000;
      n_vec++; if (bus_if.abort !== 1'b0 || bus_if.client_reset !== 4'b0000) begin
         n_err++; $display("FAIL coincide_abort got %b/%b want 0/0000", bus_if.abort, bus_if.client_reset); end
      n_vec++; if (bus_if.state_out !== 2'd2 || bus_if.grant !== 4'b0000) begin
         n_err++; $display("FAIL coincide_release got %0d/%b want 2/0000", bus_if.state_out, bus_if.grant); end
   endtask

   task automatic test_async_reset();
      int pulses = 0;
      apply_reset(4'b0100);
      step();
      #2;
      reset_n = 1'b0;
      #1;
      n_vec++; if (bus_if.grant !== 4'b0000 || bus_if.grant_valid !== 1'b0) begin
         n_err++; $display("FAIL async_drop got %b/%b want 0000/0", bus_if.grant, bus_if.grant_valid); end
      for (int k = 0; k < 3; k++) begin
         step();
         if (bus_if.client_reset != 4'b0000 || bus_if.abort) pulses++;
      end
      n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL async_pulses got %0d want 0", pulses); end
      bus_if.req = 4'b0000;
      reset_n = 1'b1;
   endtask

   task automatic test_busy();
      int bad = 0;
      logic got;
      logic [3:0] e;
      apply_reset(4'b0001);
      bus_if.i2c_bus_busy = 1'b1;
      step();
      bus_if.done = 4'b0001; bus_if.req = 4'b0010;
      step();
      bus_if.done = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.state_out !== 2'd2 || bus_if.grant_valid !== 1'b0) bad++;
         if (i < 19) step();
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL busy_hold got %0d bad cycles want 0", bad); end
      bus_if.i2c_bus_busy = 1'b0;
      exp_q.push_back(4'b0010);
      step();
      n_vec++; if (bus_if.state_out !== 2'd3) begin n_err++; $display("FAIL busy_to_guard got %0d want 3", bus_if.state_out); end
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
         if (bus_if.grant_valid) got = 1'b1;
         else step();
      end
      e = exp_q.pop_front();
      n_vec++; if (!got || bus_if.grant !== e) begin n_err++; $display("FAIL busy_next_grant got %b want %b", bus_if.grant, e); end
      bus_if.req = 4'b0000;
   endtask

   initial begin
      bus_if.req = 4'b0000; bus_if.done = 4'b0000; bus_if.fail = 4'b0000;
      bus_if.i2c_bus_busy = 1'b0;
      test_reset();
      test_basic();
      test_priority();
      test_timeout();
      test_ignore();
      test_coincide();
      test_async_reset();
      test_busy();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, the maximum cycles one grant may be held before abort.
REQ-002 SHALL have parameter GUARD_CYCLES, default 4'd4, the idle cycles enforced between grants (0 = no guard).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req, input, 4, per-client level request for the shared I2C master.
REQ-006 SHALL have port done, input, 4, per-client transaction-complete pulse (client done output).
REQ-007 SHALL have port fail, input, 4, per-client message_failure pulse.
REQ-008 SHALL have port i2c_bus_busy, input, 1, busy flag from the I2C master.
REQ-009 SHALL have port grant, output, 4, one-hot grant; the granted client alone drives the master command/data bus.
REQ-010 SHALL have port grant_valid, output, 1, high while any grant is held.
REQ-011 SHALL have port grant_id, output, 2, index of the current or last granted client.
REQ-012 SHALL have port client_reset, output, 4, one-cycle reset pulse to a client aborted by timeout.
REQ-013 SHALL have port abort, output, 1, one-cycle pulse on a timeout abort.
REQ-014 SHALL have port txn_fail, output, 1, one-cycle pulse when the granted client reports fail.
REQ-015 SHALL have port state_out, output, 2, current FSM state for debug.

Function
REQ-016 SHALL implement states S_IDLE=0, S_GRANT=1, S_RELEASE=2, S_GUARD=3.
REQ-017 In S_IDLE with req!=0, the FSM SHALL select a winner, register grant/grant_id/grant_valid, load the timer with TIMEOUT_CYCLES and enter S_GRANT; grant is visible the cycle after req is sampled (1-cycle latency).
REQ-018 In S_GRANT, the timer SHALL decrement by 1 per cycle, saturating at 0.
REQ-019 In S_GRANT, done[grant_id] or fail[grant_id] SHALL clear grant and grant_valid and enter S_RELEASE; fail additionally pulses txn_fail.
REQ-020 In S_GRANT, req[grant_id] deasserting without done SHALL be treated as a release (S_RELEASE, no txn_fail).
REQ-021 In S_GRANT, with the timer at 0, the FSM SHALL pulse abort and client_reset[grant_id] for one cycle, clear the grant and enter S_RELEASE.
REQ-022 In S_GRANT, if done/fail and timer expiry coincide, done/fail SHALL win and abort SHALL not pulse.
REQ-023 In S_GRANT, done/fail/req changes from non-granted clients SHALL be ignored; their req stays pending.
REQ-024 In S_RELEASE, the FSM SHALL wait until i2c_bus_busy==0, then load the guard counter and enter S_GUARD, or S_IDLE if GUARD_CYCLES==0.
REQ-025 S_GUARD SHALL last exactly GUARD_CYCLES cycles, then enter S_IDLE.
REQ-026 grant SHALL always be one-hot or zero; grant_valid==(grant!=0).
REQ-027 grant_id SHALL hold its last value while no grant is held.

Reset
REQ-028 On reset_n low, the block SHALL asynchronously set state=S_IDLE, grant=0, grant_valid=0, grant_id=0, client_reset=0, abort=0, txn_fail=0, timer=0, guard counter=0, and round-robin pointer=0.
REQ-029 A reset asserted mid-grant SHALL drop grant immediately and SHALL not pulse client_reset or abort.
REQ-030 After reset_n release, the first arbitration SHALL occur on the first rising edge with req!=0.

Configuration
REQ-031 With macro I2C_ARB_ROUND_ROBIN_EN defined, winner selection SHALL be round-robin: search from pointer upward with wrap 3->0, and the pointer SHALL be set to (winner+1) mod 4 at each grant.
REQ-032 Without I2C_ARB_ROUND_ROBIN_EN, winner selection SHALL be fixed priority, req[0] highest and req[3] lowest; the pointer is absent.

Verification
REQ-033 The bench SHALL cover: req=4'b0010 at reset release -> grant=4'b0010 next cycle; done[1] -> grant=0; bus idle -> S_IDLE after exactly 4 guard cycles.
REQ-034 The bench SHALL cover: req=4'b1111 held with immediate done each grant -> RR build grant order 0,1,2,3,0; non-RR build 0,0,0.
REQ-035 The bench SHALL cover: TIMEOUT_CYCLES=10, client 2 granted and never done -> abort and client_reset=4'b0100 for one cycle, 10 cycles after grant.
REQ-036 The bench SHALL cover: done[3] and fail[3] pulsed while client 1 is granted -> ignored; grant stays 4'b0010.
REQ-037 The bench SHALL cover: done at the same cycle the timer hits 0 -> no abort; reset_n low mid-grant -> grant=0 asynchronously with no client_reset pulse.
REQ-038 The bench SHALL cover: done while i2c_bus_busy=1 for 20 cycles -> state stays S_RELEASE for 20 cycles and no new grant is issued.
